// File: rtl/periph_buttons_pkg.sv
// Shared constants for the button peripheral: register offsets, ID word and
// bus handshake state encoding.
package periph_buttons_pkg;

  localparam logic [1:0]  BTN_REG_STATE  = 2'd0;
  localparam logic [1:0]  BTN_REG_STATUS = 2'd1;
  localparam logic [1:0]  BTN_REG_MASK   = 2'd2;
  localparam logic [1:0]  BTN_REG_ID     = 2'd3;

  localparam logic [31:0] BTN_ID_VALUE   = 32'h42544E00;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_ACK  = 2'd1,
    BUS_WAIT = 2'd2
  } bus_state_e;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } bus_req_t;

  // ID register content: base value with the button count folded into the low bits
  function automatic logic [31:0] btn_id_word(input logic [31:0] base, input int unsigned n);
    return base | 32'(n);
  endfunction

endpackage

// File: rtl/periph_buttons_debounce.sv
// Single-bit button conditioner: 2-flop synchroniser, stability counter and
// debounced level. rise flags the edge on which the level goes 0->1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic g_clk,
  input  logic g_rst_n,
  input  logic pin,
  output logic level,
  output logic rise
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  logic          settle;

  // The level flips on the edge where the counter would reach DEBOUNCE_CYCLES
  assign settle = (sync2 != level) && (cnt == CNT_LAST);
  assign rise   = settle && sync2;

  // Two-stage synchroniser for the asynchronous pin
  always_ff @(posedge g_clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing cycles; any agreement restarts the count
  always_ff @(posedge g_clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt   <= '0;
    end else if (settle) begin
      cnt   <= '0;
      level <= sync2;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/periph_buttons.sv
// Memory-mapped button peripheral: debounced levels, sticky rising-edge
// status (W1C), interrupt mask and a one-pulse ready handshake.
module periph_buttons
  import periph_buttons_pkg::*;
#(
  parameter int          NBUTTONS        = 8,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter logic [31:0] ID_VALUE        = BTN_ID_VALUE
) (
  input  logic                g_clk,
  input  logic                g_rst_n,
  input  logic [NBUTTONS-1:0] g_buttons,
  input  logic                sel,
  input  logic [1:0]          addr,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                ready,
  output logic                irq
);

  localparam logic [31:0] ID_WORD = btn_id_word(ID_VALUE, NBUTTONS);

  logic [NBUTTONS-1:0] level, rise, status_q, mask_q, clr;
  bus_state_e          state_q, state_d;
  bus_req_t            req;
  logic                req_vld, accept;
  logic [31:0]         rd_mux, rdata_q;
  logic                irq_q;
  logic                unused_wdata;

  assign req          = '{rd: read, wr: write, addr: addr, wdata: wdata};
  assign req_vld      = sel && (req.rd || req.wr);
  assign accept       = (state_q == BUS_IDLE) && req_vld;
  assign unused_wdata = ^req.wdata;

  for (genvar i = 0; i < NBUTTONS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .g_clk  (g_clk),
      .g_rst_n(g_rst_n),
      .pin    (g_buttons[i]),
      .level  (level[i]),
      .rise   (rise[i])
    );
  end

  // Register read mux, always sampled before any write at the same edge
  always_comb begin
    rd_mux = '0;
    case (req.addr)
      BTN_REG_STATE:  rd_mux = 32'(level);
      BTN_REG_STATUS: rd_mux = 32'(status_q);
      BTN_REG_MASK:   rd_mux = 32'(mask_q);
      default:        rd_mux = ID_WORD;
    endcase
  end

  // W1C clear vector for EDGE_STATUS; a write with read also high is a write
  always_comb begin
    clr = '0;
    if (accept && req.wr && (req.addr == BTN_REG_STATUS))
      clr = req.wdata[NBUTTONS-1:0];
  end

  // Status/mask registers, registered irq and captured read data
  always_ff @(posedge g_clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      status_q <= '0;
      mask_q   <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      status_q <= (status_q & ~clr) | rise;   // a same-edge rise beats the clear
      if (accept && req.wr && (req.addr == BTN_REG_MASK))
        mask_q <= req.wdata[NBUTTONS-1:0];
      irq_q    <= |(status_q & mask_q);
      rdata_q  <= accept ? rd_mux : '0;      // non-zero only during the ACK cycle
    end
  end

  // Bus handshake state register
  always_ff @(posedge g_clk or negedge g_rst_n) begin
    if (!g_rst_n) state_q <= BUS_IDLE;
    else          state_q <= state_d;
  end

  // Next state and ready; WAIT holds until the request drops so it is served once
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      BUS_IDLE: if (req_vld) state_d = BUS_ACK;
      BUS_ACK: begin
        ready   = 1'b1;
        state_d = BUS_WAIT;
      end
      BUS_WAIT: if (!req_vld) state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_periph_buttons.sv
// Randomised and directed bench for periph_buttons against a cycle-level
// behavioural model of pins, debounce windows, registers and handshake.
module tb_periph_buttons;

  localparam int NB = 8;
  localparam int D  = 4;

  logic          g_clk = 1'b0;
  logic          g_rst_n;
  logic [NB-1:0] g_buttons;
  logic          sel, read, write;
  logic [1:0]    addr;
  logic [31:0]   wdata, rdata;
  logic          ready, irq;

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic [NB-1:0] hist[$];
  logic [NB-1:0] m_lvl, m_status, m_mask;
  int            m_phase;
  logic          m_ready, m_irq;
  logic [31:0]   m_rdata;

  periph_buttons #(.NBUTTONS(NB), .DEBOUNCE_CYCLES(D), .ID_VALUE(32'h42544E00)) dut (
    .g_clk(g_clk), .g_rst_n(g_rst_n), .g_buttons(g_buttons), .sel(sel), .addr(addr),
    .read(read), .write(write), .wdata(wdata), .rdata(rdata), .ready(ready), .irq(irq)
  );

  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] reg_val(input logic [1:0] a, input logic [NB-1:0] lv,
                                          input logic [NB-1:0] st, input logic [NB-1:0] mk);
    case (a)
      2'd0:    return 32'(lv);
      2'd1:    return 32'(st);
      2'd2:    return 32'(mk);
      default: return 32'h42544E00 | NB;
    endcase
  endfunction

  function automatic void m_reset();
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back('0);
    m_lvl = '0; m_status = '0; m_mask = '0;
    m_phase = 0; m_ready = 1'b0; m_irq = 1'b0; m_rdata = '0;
  endfunction

  // One clock edge of the model; inputs are the values present at the edge.
  // A level flips once the last D synchronised samples all disagree with it;
  // the synchronised sample used at edge t is the pin seen at edge t-2.
  function automatic void model_step();
    logic [NB-1:0] rise, clr, lv0, st0, mk0;
    bit            req, all;
    rise = '0; clr = '0;
    lv0 = m_lvl; st0 = m_status; mk0 = m_mask;
    req = sel && (read || write);
    m_irq = |(st0 & mk0);
    hist.push_back(g_buttons);
    for (int b = 0; b < NB; b++) begin
      all = 1'b1;
      for (int i = 0; i < D; i++)
        if (hist[hist.size() - 3 - i][b] == m_lvl[b]) all = 1'b0;
      if (all) begin
        m_lvl[b] = ~m_lvl[b];
        if (m_lvl[b]) rise[b] = 1'b1;
      end
    end
    m_ready = 1'b0;
    m_rdata = '0;
    case (m_phase)
      0: if (req) begin
        m_ready = 1'b1;
        m_rdata = reg_val(addr, lv0, st0, mk0);
        if (write) begin
          if (addr == 2'd1) clr = wdata[NB-1:0];
          if (addr == 2'd2) m_mask = wdata[NB-1:0];
        end
        m_phase = 1;
      end
      1: m_phase = 2;
      default: if (!req) m_phase = 0;
    endcase
    m_status = (st0 & ~clr) | rise;
    if (hist.size() > D + 3) void'(hist.pop_front());
  endfunction

  task automatic tick();
    @(posedge g_clk);
    model_step();
    #1;
    chk("ready", 32'(ready), 32'(m_ready));
    chk("rdata", rdata, m_rdata);
    chk("irq", 32'(irq), 32'(m_irq));
    @(negedge g_clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    sel = 1'b1; read = 1'b1; write = 1'b0; addr = a;
    tick();
    chk(tag, rdata, exp);
    sel = 1'b0; read = 1'b0;
    tick(); tick();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; write = 1'b1; read = 1'b0; addr = a; wdata = d;
    tick();
    chk("wr_ready", 32'(ready), 32'h1);
    sel = 1'b0; write = 1'b0;
    tick(); tick();
  endtask

  // Press button0 before edge k and issue a STATE read accepted at edge k+dly
  task automatic press_read(input int dly, input logic [31:0] exp, input string tag);
    g_buttons = 8'h01;
    repeat (dly) tick();
    sel = 1'b1; read = 1'b1; addr = 2'd0;
    tick();
    chk(tag, rdata, exp);
    sel = 1'b0; read = 1'b0;
    tick(); tick();
  endtask

  initial begin
    int pulses;
    logic [NB-1:0] flip;
    g_rst_n = 1'b0; g_buttons = 8'hFF;
    sel = 1'b0; read = 1'b0; write = 1'b0; addr = 2'd0; wdata = '0;
    m_reset();

    // reset state
    repeat (3) @(posedge g_clk);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(negedge g_clk);
    g_rst_n = 1'b1;
    m_reset();
    idle(10);
    bus_rd(2'd0, 32'h000000FF, "post_rst_state");
    bus_rd(2'd1, 32'h000000FF, "post_rst_status");

    // debounce: short glitch ignored, exact latency of a held press
    g_buttons = 8'h00;
    idle(10);
    bus_wr(2'd1, 32'hFF);
    g_buttons = 8'h01;
    idle(3);
    g_buttons = 8'h00;
    idle(8);
    bus_rd(2'd0, 32'h0, "glitch_state");
    bus_rd(2'd1, 32'h0, "glitch_status");
    press_read(5, 32'h0, "lat_k5_state");
    g_buttons = 8'h00;
    idle(10);
    bus_wr(2'd1, 32'hFF);
    press_read(6, 32'h1, "lat_k6_state");
    bus_rd(2'd1, 32'h1, "rise_status");

    // W1C and set-over-clear priority
    g_buttons = 8'h00;
    idle(10);
    bus_wr(2'd1, 32'hFF);
    g_buttons = 8'h05;
    idle(10);
    bus_rd(2'd1, 32'h05, "status_05");
    bus_wr(2'd1, 32'h1);
    bus_rd(2'd1, 32'h04, "w1c_bit0");
    g_buttons = 8'h01;
    idle(10);
    g_buttons = 8'h05;
    repeat (5) tick();
    sel = 1'b1; write = 1'b1; addr = 2'd1; wdata = 32'h4;
    tick();
    sel = 1'b0; write = 1'b0;
    tick(); tick();
    bus_rd(2'd1, 32'h04, "set_wins");

    // irq timing
    bus_wr(2'd1, 32'hFF);
    bus_wr(2'd2, 32'h2);
    g_buttons = 8'h07;
    repeat (5) tick();
    tick();
    chk("irq_at_set", 32'(irq), 32'h0);
    tick();
    chk("irq_after_set", 32'(irq), 32'h1);
    sel = 1'b1; write = 1'b1; addr = 2'd1; wdata = 32'h2;
    tick();
    chk("irq_hold", 32'(irq), 32'h1);
    sel = 1'b0; write = 1'b0;
    tick();
    chk("irq_drop", 32'(irq), 32'h0);
    tick();
    bus_rd(2'd2, 32'h2, "mask_rd");

    // handshake: held request served once, then minimum spacing
    pulses = 0;
    sel = 1'b1; read = 1'b1; addr = 2'd0;
    repeat (6) begin
      tick();
      if (ready) pulses++;
    end
    chk("held_pulses", 32'(pulses), 32'h1);
    sel = 1'b0; read = 1'b0;
    tick(); tick();
    sel = 1'b1; read = 1'b1;
    tick();
    chk("sp_first", 32'(ready), 32'h1);
    tick();
    chk("sp_ack_end", 32'(ready), 32'h0);
    sel = 1'b0; read = 1'b0;
    tick();
    chk("sp_wait", 32'(ready), 32'h0);
    sel = 1'b1; read = 1'b1;
    tick();
    chk("sp_second", 32'(ready), 32'h1);
    sel = 1'b0; read = 1'b0;
    tick(); tick();

    // ID and read-only registers
    bus_rd(2'd3, 32'h42544E08, "id");
    bus_wr(2'd0, 32'hDEADBEEF);
    bus_rd(2'd0, 32'h07, "state_ro");

    // randomised traffic
    repeat (1500) begin
      flip = '0;
      for (int b = 0; b < NB; b++) if ($urandom_range(0, 9) == 0) flip[b] = 1'b1;
      g_buttons = g_buttons ^ flip;
      sel   = ($urandom_range(0, 2) == 0);
      read  = 1'($urandom);
      write = 1'($urandom);
      addr  = 2'($urandom);
      wdata = $urandom;
      tick();
    end
    sel = 1'b0; read = 1'b0; write = 1'b0;
    idle(3);

    // reset during the ACK cycle aborts the access
    sel = 1'b1; write = 1'b1; addr = 2'd2; wdata = 32'hFF;
    tick();
    #2 g_rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    chk("abort_irq", 32'(irq), 32'h0);
    @(negedge g_clk);
    sel = 1'b0; write = 1'b0;
    g_rst_n = 1'b1;
    m_reset();
    bus_rd(2'd2, 32'h0, "mask_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
